// File: rtl/fpu_arbiter_pkg.sv
// rtl/fpu_arbiter_pkg.sv - shared op encodings, FSM states and default latencies for fpu_arbiter
package fpu_arbiter_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int DEF_ADD_LAT = 1;
  localparam int DEF_MUL_LAT = 2;
  localparam int DEF_DIV_LAT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/fpu_rr_arb.sv
// rtl/fpu_rr_arb.sv - two-requester round-robin selector with one-hot grant
module fpu_rr_arb (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // A lone requester wins outright; on a tie the one not served last wins.
  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = last_grant_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - shares one combinational FPU between two requesters; FPU_ARBITER_STATS_EN adds grant counters
module fpu_arbiter
  import fpu_arbiter_pkg::*;
#(
  parameter int ADD_LAT = DEF_ADD_LAT,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [1:0]  req0_op,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [1:0]  req1_op,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  output logic        req1_ready,
  output logic [1:0]  fpu_op,
  output logic [63:0] fpu_a,
  output logic [63:0] fpu_b,
  input  logic [63:0] fpu_result,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [63:0] rsp_result,
  input  logic        rsp_ready,
  output logic        busy
`ifdef FPU_ARBITER_STATS_EN
  ,
  output logic [31:0] grant_cnt0,
  output logic [31:0] grant_cnt1
`endif
);

  localparam int MAX_LAT = (ADD_LAT > MUL_LAT) ?
                           ((ADD_LAT > DIV_LAT) ? ADD_LAT : DIV_LAT) :
                           ((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT);
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              id_q, id_d;
  logic [1:0]        op_q, op_d;
  logic [63:0]       a_q, a_d;
  logic [63:0]       b_q, b_d;
  logic [63:0]       result_q, result_d;

  logic [1:0]        grant;
  logic [1:0]        sel_op;
  logic [CNT_W-1:0]  load_cnt;

`ifdef FPU_ARBITER_STATS_EN
  logic [31:0]       gcnt0_q, gcnt0_d;
  logic [31:0]       gcnt1_q, gcnt1_d;
`endif

  fpu_rr_arb u_rr_arb (
    .req_i        ({req1_valid, req0_valid}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  assign sel_op = grant[1] ? req1_op : req0_op;

  // Counter preload is latency minus one so that EXEC spans exactly the op latency.
  always_comb begin
    case (sel_op)
      OP_MUL:  load_cnt = CNT_W'(MUL_LAT - 1);
      OP_DIV:  load_cnt = CNT_W'(DIV_LAT - 1);
      default: load_cnt = CNT_W'(ADD_LAT - 1);
    endcase
  end

  // Next-state and handshake logic; ready is only offered while IDLE.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
`ifdef FPU_ARBITER_STATS_EN
    gcnt0_d      = gcnt0_q;
    gcnt1_d      = gcnt1_q;
`endif
    case (state_q)
      ST_IDLE: begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        if (|grant) begin
          op_d         = sel_op;
          a_d          = grant[1] ? req1_a : req0_a;
          b_d          = grant[1] ? req1_b : req0_b;
          id_d         = grant[1];
          last_grant_d = grant[1];
          cnt_d        = load_cnt;
          state_d      = ST_EXEC;
`ifdef FPU_ARBITER_STATS_EN
          if (grant[0]) gcnt0_d = gcnt0_q + 32'd1;
          if (grant[1]) gcnt1_d = gcnt1_q + 32'd1;
`endif
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          result_d = fpu_result;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= 2'b00;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
`ifdef FPU_ARBITER_STATS_EN
      gcnt0_q      <= '0;
      gcnt1_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
`ifdef FPU_ARBITER_STATS_EN
      gcnt0_q      <= gcnt0_d;
      gcnt1_q      <= gcnt1_d;
`endif
    end
  end

  assign fpu_op     = op_q;
  assign fpu_a      = a_q;
  assign fpu_b      = b_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef FPU_ARBITER_STATS_EN
  assign grant_cnt0 = gcnt0_q;
  assign grant_cnt1 = gcnt1_q;
`endif

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb/tb_fpu_arbiter.sv - directed table-driven bench for fpu_arbiter
module tb_fpu_arbiter;
  import fpu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [1:0]  req0_op, req1_op;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic [1:0]  fpu_op;
  logic [63:0] fpu_a, fpu_b, fpu_result;
  logic        rsp_valid, rsp_id, rsp_ready, busy;
  logic [63:0] rsp_result;
`ifdef FPU_ARBITER_STATS_EN
  logic [31:0] grant_cnt0, grant_cnt1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpu_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .fpu_op     (fpu_op),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_result (fpu_result),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
`ifdef FPU_ARBITER_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  // Behavioural stand-in for the shared combinational FPU.
  real ra, rb, rr;
  always_comb begin
    ra = $bitstoreal(fpu_a);
    rb = $bitstoreal(fpu_b);
    rr = 0.0;
    case (fpu_op)
      2'b00:   rr = ra + rb;
      2'b01:   rr = ra - rb;
      2'b10:   rr = ra * rb;
      default: rr = (rb != 0.0) ? ra / rb : 0.0;
    endcase
    fpu_result = $realtobits(rr);
  end

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    int          lat;
    logic [63:0] res;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic id, input logic v, input logic [1:0] op,
                         input logic [63:0] a, input logic [63:0] b);
    if (id) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Raise valid, wait (bounded) for ready, take the transfer edge, then drop valid.
  task automatic issue(input logic id, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    int n;
    @(negedge clk);
    set_req(id, 1'b1, op, a, b);
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout actual=no_ready required=ready id=%0d", id);
    end
    @(posedge clk);
    #1;
    set_req(id, 1'b0, op, a, b);
  endtask

  // Count edges from the transfer edge until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!rsp_valid && lat < 20);
  endtask

  task automatic complete();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("resp_exit_busy", {63'd0, busy}, 64'd0);
  endtask

  int lat;
  int g_id[$];
  int g_cyc[$];
  int n0, n1;
  logic [63:0] held;

  initial begin
    reset = 1'b0;
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
    set_req(1'b1, 1'b0, 2'b00, 64'd0, 64'd0);

    vecs[0] = '{1'b0, OP_ADD, 64'h3FF0000000000000, 64'h4000000000000000, 1, 64'h4008000000000000};
    vecs[1] = '{1'b1, OP_MUL, 64'h4000000000000000, 64'h4008000000000000, 2, 64'h4018000000000000};
    vecs[2] = '{1'b0, OP_SUB, 64'h4008000000000000, 64'h3FF0000000000000, 1, 64'h4000000000000000};
    vecs[3] = '{1'b1, OP_DIV, 64'h4018000000000000, 64'h4000000000000000, 4, 64'h4008000000000000};
    vecs[4] = '{1'b0, OP_MUL, 64'h3FF8000000000000, 64'h4000000000000000, 2, 64'h4008000000000000};

    // Reset state
    #12;
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rsp_id", {63'd0, rsp_id}, 64'd0);
    chk("rst_rsp_result", rsp_result, 64'd0);
    chk("rst_fpu_op", {62'd0, fpu_op}, 64'd0);
    chk("rst_fpu_a", fpu_a, 64'd0);
    chk("rst_fpu_b", fpu_b, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven single transactions
    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
      wait_rsp(lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_rsp_valid", i), {63'd0, rsp_valid}, 64'd1);
      chk($sformatf("v%0d_rsp_id", i), {63'd0, rsp_id}, {63'd0, vecs[i].id});
      chk($sformatf("v%0d_rsp_result", i), rsp_result, vecs[i].res);
      chk($sformatf("v%0d_fpu_a_held", i), fpu_a, vecs[i].a);
      chk($sformatf("v%0d_fpu_op_held", i), {62'd0, fpu_op}, {62'd0, vecs[i].op});
      chk($sformatf("v%0d_busy", i), {63'd0, busy}, 64'd1);
      complete();
    end

    // Contention: both valid, response always accepted, add latency 1 -> period 3
    do_reset();
    rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, OP_ADD, 64'h3FF0000000000000, 64'h3FF0000000000000);
    set_req(1'b1, 1'b1, OP_ADD, 64'h4000000000000000, 64'h4000000000000000);
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req0_ready && req1_ready) begin
        checks++;
        failures++;
        $display("FAIL cont_both_ready actual=11 required=one_hot cycle=%0d", c);
      end
      if (req0_ready) begin g_id.push_back(0); g_cyc.push_back(c); n0++; end
      if (req1_ready) begin g_id.push_back(1); g_cyc.push_back(c); n1++; end
      @(negedge clk);
    end
    set_req(1'b0, 1'b0, OP_ADD, 64'd0, 64'd0);
    set_req(1'b1, 1'b0, OP_ADD, 64'd0, 64'd0);
    rsp_ready = 1'b0;
    chk("cont_grant_count", 64'(g_id.size()), 64'd4);
    chk("cont_ready0_pulses", 64'(n0), 64'd2);
    chk("cont_ready1_pulses", 64'(n1), 64'd2);
    for (int k = 0; k < 4 && k < g_id.size(); k++) begin
      chk($sformatf("cont_grant%0d_id", k), 64'(g_id[k]), 64'(k % 2));
      chk($sformatf("cont_grant%0d_cycle", k), 64'(g_cyc[k]), 64'(3 * k));
    end

    // Backpressure on a div with a competing requester waiting
    do_reset();
    issue(1'b0, OP_DIV, 64'h4018000000000000, 64'h4000000000000000);
    wait_rsp(lat);
    chk("bp_latency", 64'(lat), 64'd4);
    held = rsp_result;
    chk("bp_result", held, 64'h4008000000000000);
    set_req(1'b1, 1'b1, OP_MUL, 64'h4000000000000000, 64'h4000000000000000);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("bp_c%0d_state", c),
          {58'd0, rsp_valid, rsp_id, req0_ready, req1_ready, busy, 1'b0},
          {58'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
      chk($sformatf("bp_c%0d_result", c), rsp_result, held);
    end
    // Drop the competing valid before IDLE; it must be ignored afterwards.
    set_req(1'b1, 1'b0, OP_MUL, 64'd0, 64'd0);
    complete();
    chk("bp_exit_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    @(posedge clk);
    #1;
    chk("bp_dropped_req_ignored", {63'd0, busy}, 64'd0);

    // Reset abort in the second EXEC cycle of a div
    issue(1'b0, OP_DIV, 64'h4018000000000000, 64'h4000000000000000);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("abort_rsp_id", {63'd0, rsp_id}, 64'd0);
    chk("abort_rsp_result", rsp_result, 64'd0);
    chk("abort_fpu_op", {62'd0, fpu_op}, 64'd0);
    chk("abort_fpu_a", fpu_a, 64'd0);
    chk("abort_fpu_b", fpu_b, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    n0 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid || busy) n0++;
    end
    chk("abort_no_late_rsp", 64'(n0), 64'd0);

`ifdef FPU_ARBITER_STATS_EN
    do_reset();
    for (int k = 0; k < 5; k++) begin
      issue((k == 1 || k == 3), OP_ADD, 64'h3FF0000000000000, 64'h3FF0000000000000);
      wait_rsp(lat);
      complete();
    end
    chk("stats_cnt0", {32'd0, grant_cnt0}, 64'd3);
    chk("stats_cnt1", {32'd0, grant_cnt1}, 64'd2);
    @(negedge clk);
    dut.gcnt0_q = 32'hFFFFFFFF;
    issue(1'b0, OP_ADD, 64'h3FF0000000000000, 64'h3FF0000000000000);
    chk("stats_wrap", {32'd0, grant_cnt0}, 64'd0);
    wait_rsp(lat);
    complete();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 The block SHALL have parameter ADD_LAT, default 1, meaning EXEC cycles for op 00/01 (minimum 1).
REQ-002 The block SHALL have parameter MUL_LAT, default 2, meaning EXEC cycles for op 10 (minimum 1).
REQ-003 The block SHALL have parameter DIV_LAT, default 4, meaning EXEC cycles for op 11 (minimum 1).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL be updated on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset (reset=0 resets).
REQ-006 The block SHALL have ports reqN_valid (input, 1), reqN_op (input, 2; 00 add, 01 sub, 10 mul, 11 div), reqN_a (input, 64), reqN_b (input, 64) and reqN_ready (output, 1), for N = 0 and 1.
REQ-007 The block SHALL have ports fpu_op (output, 2), fpu_a (output, 64), fpu_b (output, 64) and fpu_result (input, 64), connecting to the shared combinational fpu.
REQ-008 The block SHALL have ports rsp_valid (output, 1), rsp_id (output, 1; the requester index), rsp_result (output, 64) and rsp_ready (input, 1).
REQ-009 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-011 reqN_ready SHALL be combinational, high only in IDLE for the requester selected by arbitration; all other ready outputs SHALL be low.
REQ-012 Arbitration SHALL be round-robin:
- a sole valid requester wins;
- when both are valid, the requester other than last_grant wins;
- last_grant SHALL reset to 1, so requester 0 wins the first tie.
REQ-013 On a transfer edge (valid&ready) the block SHALL:
- latch op, a and b into operand registers;
- set rsp_id to the winner;
- update last_grant;
- load the counter with the op latency minus 1;
- move to EXEC.
REQ-014 fpu_op, fpu_a and fpu_b SHALL be driven from the operand registers only, and SHALL hold their values in all states.
REQ-015 EXEC SHALL last exactly the op latency in cycles. When the counter is 0, the block SHALL capture fpu_result into rsp_result and move to RESP. Otherwise it SHALL decrement the counter.
REQ-016 rsp_valid SHALL be high exactly while in RESP. It SHALL first be observed high LAT edges after the transfer edge.
REQ-017 In RESP, if rsp_ready=1 the block SHALL return to IDLE on that edge. Otherwise rsp_valid, rsp_id and rsp_result SHALL hold stable indefinitely.
REQ-018 No new request SHALL be accepted in EXEC or RESP. A request SHALL be accepted at the earliest in the cycle after RESP exits, giving a minimum spacing of LAT+2 cycles between issues.
REQ-019 A requester dropping valid before ready SHALL be treated as no request; no latch and no state change SHALL occur.

Reset
REQ-020 While reset=0, the block SHALL:
- put the state in IDLE;
- clear the counter and set last_grant to 1;
- drive rsp_valid 0, rsp_id 0, rsp_result 0, busy 0, and fpu_op/fpu_a/fpu_b 0.
REQ-021 A reset asserted mid-EXEC or mid-RESP SHALL abort the operation immediately; no response SHALL be produced afterwards.

Configuration
REQ-022 With FPU_ARBITER_STATS_EN defined, the block SHALL add outputs grant_cnt0 and grant_cnt1 (32 bits each). Each SHALL increment on every transfer for its requester, wrap from FFFFFFFF to 0, and reset to 0.
REQ-023 Without FPU_ARBITER_STATS_EN, those ports and their counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-024 A shared package SHALL hold:
- the 2-bit op encodings;
- the FSM state enumeration;
- the default latency constants.
REQ-025 The round-robin selector SHALL be a sub-module, fpu_rr_arb (2 requesters, last_grant input, one-hot grant output). The FSM, counter and registers SHALL remain in fpu_arbiter.

Verification
REQ-026 The bench SHALL cover single add: req0 op=00, a=3FF0000000000000 (1.0), b=4000000000000000 (2.0), default params -> rsp_valid 1 edge after accept, rsp_id=0, rsp_result=4008000000000000.
REQ-027 The bench SHALL cover mul latency: req1 op=10, a=4000000000000000, b=4008000000000000 -> rsp_valid exactly 2 edges after accept, rsp_id=1, rsp_result=4018000000000000.
REQ-028 The bench SHALL cover contention: both valid continuously after reset -> grants alternate 0,1,0,1 and each reqN_ready pulses once per LAT+2-cycle period.
REQ-029 The bench SHALL cover backpressure: div op (DIV_LAT=4) with rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_result stable throughout, both ready signals 0, busy=1; rsp_ready=1 -> IDLE next edge.
REQ-030 The bench SHALL cover reset abort: reset=0 during the 2nd EXEC cycle of a div -> all outputs at reset values asynchronously and no rsp_valid after reset release.
REQ-031 The bench SHALL cover stats (FPU_ARBITER_STATS_EN defined): 3 grants to req0 and 2 to req1 -> grant_cnt0=3 and grant_cnt1=2; a preloaded FFFFFFFF wraps to 0 on the next grant.
